// File: rtl/capture_window_ctrl_pkg.sv
// Shared types and helpers for the capture window sequencer.
package capture_window_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ARMED = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [4:0] lsb_idx(input logic [31:0] v);
    lsb_idx = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) lsb_idx = 5'(i);
  endfunction

endpackage

// File: rtl/capture_window_ctrl_flag_sync.sv
// Multi-flop synchronizer for the incoming capture flags; clears to 0 on reset.
module capture_window_ctrl_flag_sync #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [N_CH-1:0] flag_i,
  output logic [N_CH-1:0] sflag_o
);

  logic [SYNC_STAGES-1:0][N_CH-1:0] pipe_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= flag_i;
      for (int s = 1; s < SYNC_STAGES; s++)
        pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign sflag_o = pipe_q[SYNC_STAGES-1];

endmodule

// File: rtl/capture_window_ctrl.sv
// Run sequencer for the edge-capture bank: clear, timed acquisition window,
// per-channel first-edge timestamps and a start/done/ack host handshake.
module capture_window_ctrl
  import capture_window_ctrl_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int TS_W        = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYC     = 4,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            ack_i,
  input  logic [TS_W-1:0] window_i,
  input  logic [N_CH-1:0] mask_i,
  input  logic [N_CH-1:0] flag_i,
  input  logic [CH_W-1:0] rd_sel_i,
  output logic            clr_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o,
  output logic [N_CH-1:0] hit_o,
  output logic [CH_W-1:0] first_ch_o,
  output logic [TS_W-1:0] first_ts_o,
  output logic            any_hit_o,
  output logic [TS_W-1:0] rd_ts_o
);

  localparam int CC_W = $clog2(CLR_CYC + 1);

  state_e                      state_q, state_d;
  logic [TS_W-1:0]             cnt_q, cnt_d;
  logic [CC_W-1:0]             ccnt_q, ccnt_d;
  logic [TS_W-1:0]             window_q, window_d;
  logic [N_CH-1:0]             mask_q, mask_d;
  logic [N_CH-1:0]             hit_q, hit_d;
  logic [N_CH-1:0][TS_W-1:0]   ts_q, ts_d;
  logic [CH_W-1:0]             first_ch_q, first_ch_d;
  logic [TS_W-1:0]             first_ts_q, first_ts_d;
  logic                        any_hit_q, any_hit_d;
  logic                        timeout_q, timeout_d;
  logic [TS_W-1:0]             rd_ts_q;

  logic [N_CH-1:0]             sflag;
  logic [N_CH-1:0]             new_hits;
  logic                        all_hit;
  logic                        expire;

  capture_window_ctrl_flag_sync #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_flag_sync (
    .clk     (clk),
    .clrn    (clrn),
    .flag_i  (flag_i),
    .sflag_o (sflag)
  );

  assign new_hits = mask_q & sflag & ~hit_q;
  assign all_hit  = (((hit_q | new_hits) & mask_q) == mask_q);
  // window 0 wraps to all-ones here, giving a full 2^TS_W cycle window.
  assign expire   = (cnt_q == window_q - TS_W'(1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ccnt_d     = ccnt_q;
    window_d   = window_q;
    mask_d     = mask_q;
    hit_d      = hit_q;
    ts_d       = ts_q;
    first_ch_d = first_ch_q;
    first_ts_d = first_ts_q;
    any_hit_d  = any_hit_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = CLEAR;
          window_d   = window_i;
          mask_d     = mask_i;
          hit_d      = '0;
          ts_d       = '0;
          first_ch_d = '0;
          first_ts_d = '0;
          any_hit_d  = 1'b0;
          timeout_d  = 1'b0;
          cnt_d      = '0;
          ccnt_d     = '0;
        end
      end
      CLEAR: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (ccnt_q == CC_W'(CLR_CYC - 1)) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else begin
          ccnt_d = ccnt_q + CC_W'(1);
        end
      end
      ARMED: begin
        // Abort takes priority; the aborting cycle records no captures.
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TS_W'(1);
          hit_d = hit_q | new_hits;
          for (int i = 0; i < N_CH; i++)
            if (new_hits[i]) ts_d[i] = cnt_q;
          if (!any_hit_q && (|new_hits)) begin
            first_ch_d = CH_W'(lsb_idx(32'(new_hits)));
            first_ts_d = cnt_q;
            any_hit_d  = 1'b1;
          end
          if (all_hit) begin
            state_d   = DONE;
            timeout_d = 1'b0;
          end else if (expire) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q      <= '0;
      ccnt_q     <= '0;
      window_q   <= '0;
      mask_q     <= '0;
      hit_q      <= '0;
      ts_q       <= '0;
      first_ch_q <= '0;
      first_ts_q <= '0;
      any_hit_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ccnt_q     <= ccnt_d;
      window_q   <= window_d;
      mask_q     <= mask_d;
      hit_q      <= hit_d;
      ts_q       <= ts_d;
      first_ch_q <= first_ch_d;
      first_ts_q <= first_ts_d;
      any_hit_q  <= any_hit_d;
      timeout_q  <= timeout_d;
    end
  end

  // Non-power-of-two banks read 0 for select values past the last channel.
  if (N_CH == (1 << CH_W)) begin : g_rd_pow2
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) rd_ts_q <= '0;
      else       rd_ts_q <= ts_q[rd_sel_i];
    end
  end else begin : g_rd_np2
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)                        rd_ts_q <= '0;
      else if (rd_sel_i < CH_W'(N_CH))  rd_ts_q <= ts_q[rd_sel_i];
      else                              rd_ts_q <= '0;
    end
  end

  assign clr_o      = (state_q != ARMED);
  assign busy_o     = (state_q == CLEAR) || (state_q == ARMED);
  assign done_o     = (state_q == DONE);
  assign timeout_o  = timeout_q;
  assign hit_o      = hit_q;
  assign first_ch_o = first_ch_q;
  assign first_ts_o = first_ts_q;
  assign any_hit_o  = any_hit_q;
  assign rd_ts_o    = rd_ts_q;

endmodule

// File: tb/tb_capture_window_ctrl.sv
// Directed bench: run-level result model plus per-cycle handshake/clear checks.
module tb_capture_window_ctrl;

  localparam int N  = 8;
  localparam int TW = 16;
  localparam int SS = 2;
  localparam int CC = 4;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, ack_i = 1'b0;
  logic [TW-1:0] window_i = '0;
  logic [N-1:0]  mask_i = '0, flag_i = '0;
  logic [2:0]    rd_sel_i = '0;
  logic          clr_o, busy_o, done_o, timeout_o, any_hit_o;
  logic [N-1:0]  hit_o;
  logic [2:0]    first_ch_o;
  logic [TW-1:0] first_ts_o, rd_ts_o;

  // Second instance with a 4-bit counter for the window=0 wrap case.
  logic          start4 = 1'b0;
  logic [3:0]    window4 = '0;
  logic [N-1:0]  mask4 = 8'h01, flag4 = '0;
  logic          clr4, busy4, done4, timeout4, any4;
  logic [N-1:0]  hit4;
  logic [2:0]    fch4;
  logic [3:0]    fts4, rdts4;

  always #5 clk = ~clk;

  capture_window_ctrl #(.N_CH(N), .TS_W(TW), .SYNC_STAGES(SS), .CLR_CYC(CC)) u_dut (
    .clk(clk), .clrn(clrn), .start_i(start_i), .abort_i(abort_i), .ack_i(ack_i),
    .window_i(window_i), .mask_i(mask_i), .flag_i(flag_i), .rd_sel_i(rd_sel_i),
    .clr_o(clr_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .hit_o(hit_o), .first_ch_o(first_ch_o), .first_ts_o(first_ts_o),
    .any_hit_o(any_hit_o), .rd_ts_o(rd_ts_o));

  capture_window_ctrl #(.N_CH(N), .TS_W(4), .SYNC_STAGES(SS), .CLR_CYC(CC)) u_dut4 (
    .clk(clk), .clrn(clrn), .start_i(start4), .abort_i(abort_i), .ack_i(ack_i),
    .window_i(window4), .mask_i(mask4), .flag_i(flag4), .rd_sel_i(rd_sel_i),
    .clr_o(clr4), .busy_o(busy4), .done_o(done4), .timeout_o(timeout4),
    .hit_o(hit4), .first_ch_o(fch4), .first_ts_o(fts4),
    .any_hit_o(any4), .rd_ts_o(rdts4));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus: ARMED count at which each channel's flag rises (-1 = never).
  int rise [N];

  // Expected run results.
  logic [N-1:0] e_hit;
  int           e_ts [N];
  int           e_first_ch, e_first_ts, e_armed;
  logic         e_any, e_timeout, e_abort;
  int           start_cyc;
  logic         run_on = 1'b0;

  // Run-level model: each enabled channel lands at rise+SS; the run ends at the
  // latest such landing if it fits in the window, else at window-1 (or the abort).
  task automatic model(input logic [N-1:0] m, input int w, input int abort_at);
    int len, tall, last, best;
    logic allok;
    len  = (w == 0) ? (1 << TW) : w;
    tall = 0;
    allok = 1'b1;
    for (int i = 0; i < N; i++)
      if (m[i]) begin
        if (rise[i] < 0) allok = 1'b0;
        else if (rise[i] + SS > tall) tall = rise[i] + SS;
      end
    e_abort = (abort_at >= 0);
    e_timeout = 1'b0;
    if (e_abort) begin
      e_armed = abort_at + 1;
      last    = abort_at - 1;
    end else if (allok && tall <= len - 1) begin
      e_armed = tall + 1;
      last    = tall;
    end else begin
      e_armed   = len;
      last      = len - 1;
      e_timeout = 1'b1;
    end
    e_hit = '0;
    best  = -1;
    e_first_ch = 0;
    e_first_ts = 0;
    for (int i = 0; i < N; i++) begin
      e_ts[i] = 0;
      if (m[i] && rise[i] >= 0 && rise[i] + SS <= last) begin
        e_hit[i] = 1'b1;
        e_ts[i]  = rise[i] + SS;
        if (best < 0 || e_ts[i] < best) begin
          best = e_ts[i];
          e_first_ch = i;
          e_first_ts = e_ts[i];
        end
      end
    end
    e_any = (e_hit != '0);
  endtask

  // Per-cycle compare during a run, indexed by cycles since start was taken.
  always @(negedge clk) begin : cmp
    int n;
    if (run_on) begin
      n = cyc - start_cyc;
      chk("busy", busy_o, n < CC + e_armed);
      chk("clr", clr_o, !(n >= CC && n < CC + e_armed));
      chk("done", done_o, !e_abort && n >= CC + e_armed);
      if (n < CC) begin
        chk("hit_cleared", hit_o, '0);
        chk("any_cleared", any_hit_o, 1'b0);
      end
      if (n >= CC + e_armed) begin
        chk("timeout", timeout_o, e_timeout);
        chk("hit", hit_o, e_hit);
        chk("any_hit", any_hit_o, e_any);
        chk("first_ch", first_ch_o, e_first_ch);
        chk("first_ts", first_ts_o, e_first_ts);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_rise();
    for (int i = 0; i < N; i++) rise[i] = -1;
  endtask

  task automatic run(input logic [N-1:0] m, input int w, input int abort_at, input int poke);
    int c;
    model(m, w, abort_at);
    mask_i   = m;
    window_i = TW'(w);
    start_i  = 1'b1;
    tick();
    start_i   = 1'b0;
    start_cyc = cyc;
    run_on    = 1'b1;
    for (int n = 0; n <= CC + e_armed + 1; n++) begin
      c = n - CC;
      if (c >= 0) begin
        for (int i = 0; i < N; i++)
          if (rise[i] == c) flag_i[i] = 1'b1;
        abort_i = (c == abort_at);
        start_i = (c == poke);
      end
      tick();
      abort_i = 1'b0;
      start_i = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      rd_sel_i = 3'(i);
      @(posedge clk);
      @(negedge clk);
      chk("rd_ts", rd_ts_o, e_ts[i]);
      #1;
    end
    tick();
    ack_i = 1'b1;
    tick();
    ack_i  = 1'b0;
    run_on = 1'b0;
    flag_i = '0;
    @(negedge clk);
    chk("idle_done", done_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_hit_held", hit_o, e_hit);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int armed;
    // Reset values
    #12;
    chk("rst_clr", clr_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_any", any_hit_o, 1'b0);
    chk("rst_hit", hit_o, '0);
    chk("rst_first", {first_ch_o, first_ts_o}, '0);
    chk("rst_rdts", rd_ts_o, '0);
    chk("rst_clr4", clr4, 1'b1);
    clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_stays", {busy_o, done_o, clr_o}, 3'b001);
    end
    tick();

    // window=0 on a 4-bit counter: full 16-cycle window then timeout
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    armed = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done4) break;
      if (busy4 && !clr4) armed++;
    end
    chk("w0_done", done4, 1'b1);
    chk("w0_armed_cycles", armed, 16);
    chk("w0_timeout", timeout4, 1'b1);
    chk("w0_hit", hit4, '0);
    tick();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    @(negedge clk);
    chk("w0_acked", done4, 1'b0);
    tick();

    // Full hit, staggered flags
    clr_rise();
    rise[2] = 10; rise[0] = 20; rise[3] = 30; rise[1] = 40;
    run(8'h0F, 100, -1, -1);
    chk("full_first_ch", first_ch_o, 3'd2);
    chk("full_first_ts", first_ts_o, 16'd12);
    chk("full_timeout", timeout_o, 1'b0);
    chk("full_hit", hit_o, 8'h0F);

    // Timeout with one enabled channel silent
    clr_rise();
    rise[0] = 1;
    run(8'h03, 5, -1, -1);
    chk("to_timeout", timeout_o, 1'b1);
    chk("to_hit", hit_o, 8'h01);

    // Simultaneous hits, masked channel ignored
    clr_rise();
    rise[5] = 15; rise[3] = 15; rise[7] = 5;
    run(8'h28, 50, -1, -1);
    chk("sim_first_ch", first_ch_o, 3'd3);
    chk("sim_first_ts", first_ts_o, 16'd17);
    chk("sim_hit", hit_o, 8'h28);

    // All-hit on the final window cycle beats timeout
    clr_rise();
    rise[0] = 10;
    run(8'h01, 13, -1, -1);
    chk("tie_timeout", timeout_o, 1'b0);
    chk("tie_first_ts", first_ts_o, 16'd12);

    // Abort at cnt 7, with a stray start during ARMED and ack while idle
    clr_rise();
    rise[1] = 2;
    run(8'h0F, 100, 7, 3);
    chk("abort_hit", hit_o, 8'h02);
    chk("abort_first_ts", first_ts_o, 16'd4);
    chk("abort_any", any_hit_o, 1'b1);

    // No channels enabled
    clr_rise();
    rise[4] = 0;
    run(8'h00, 100, -1, -1);
    chk("m0_timeout", timeout_o, 1'b0);
    chk("m0_hit", hit_o, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_window_ctrl.md
# capture_window_ctrl

Sequencer for a bank of edge-capture input registers in the signal-conditioning tester. On each test run it clears every channel's capture flop, opens a programmable acquisition window and timestamps the first edge seen on each enabled channel. It reports per-channel hit flags, first-hit channel and timeout status to the host through a start/done/ack handshake. It sits between the host register interface and the N capture channels, and drives their common clear line.

## Interface
Parameters:
- N_CH, 8, number of capture channels (2..32)
- TS_W, 16, timestamp/window counter width
- SYNC_STAGES, 2, extra synchronizer flops on each incoming flag (>=1)
- CLR_CYC, 4, cycles clr_o is held in CLEAR; must be >= SYNC_STAGES+2

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- start_i  in  1  pulse: begin a run; honoured only in IDLE
- abort_i  in  1  level/pulse: cancel a run in CLEAR or ARMED
- ack_i  in  1  host acknowledge of results; honoured only in DONE
- window_i  in  TS_W  window length in clk cycles, sampled on accepted start; 0 = 2^TS_W
- mask_i  in  N_CH  channel enable, sampled on accepted start
- flag_i  in  N_CH  capture flags from channel registers
- rd_sel_i  in  $clog2(N_CH)  timestamp readout select
- clr_o  out  1  active-high clear to all capture channels
- busy_o  out  1  high in CLEAR and ARMED
- done_o  out  1  high in DONE
- timeout_o  out  1  window expired before all enabled channels hit
- hit_o  out  N_CH  per-channel hit flags
- first_ch_o  out  $clog2(N_CH)  index of first channel hit
- first_ts_o  out  TS_W  timestamp of first hit
- any_hit_o  out  1  at least one enabled channel hit
- rd_ts_o  out  TS_W  timestamp of channel rd_sel_i

## Operation
- States: IDLE, CLEAR, ARMED, DONE.
- IDLE: clr_o=1. start_i -> latch window_i and mask_i; zero hit, timestamps, first_*, timeout and any_hit; cnt=0; go to CLEAR.
- CLEAR: clr_o=1 for exactly CLR_CYC cycles, flushing the channel flops and the synchronizer chain with 0. Then go to ARMED with cnt=0.
- ARMED: clr_o=0; cnt increments each cycle.
  - Capture: for each channel i with mask[i] & sflag[i] & ~hit[i], set hit[i] and ts[i]=cnt. sflag is the synchronized flag.
  - First hit: when any_hit is 0 and new hits occur, first_ch=lowest new index and first_ts=cnt. any_hit is set.
- Exit from ARMED, evaluated including this cycle's captures:
  - All enabled channels hit ((hit|new)&mask == mask): go to DONE, timeout=0.
  - Otherwise, cnt == window-1 (modulo 2^TS_W): go to DONE, timeout=1.
  - Both conditions on the same cycle: all-hit wins, timeout=0.
- mask=0: all-hit is true on the first ARMED cycle, so DONE follows after 1 cycle with timeout=0 and no hits.
- DONE: clr_o=1; results held stable; ack_i -> IDLE. Results remain readable in IDLE until the next start.
- abort_i in CLEAR or ARMED -> IDLE next cycle. done_o is never raised and results hold partial values. abort_i is ignored in IDLE and DONE.
- start_i outside IDLE and ack_i outside DONE are ignored.
- Readout: rd_ts_o is registered and shows ts[rd_sel_i] one cycle after rd_sel_i. Channels that did not hit read 0.

## Timing
- Reset (clrn=0): state=IDLE, clr_o=1; busy_o, done_o, timeout_o, any_hit_o=0; hit_o, first_ch_o, first_ts_o, rd_ts_o=0; synchronizers=0.
- Run sequence:
  - start_i sampled at edge k: busy_o=1 and CLEAR begins after edge k.
  - clr_o deasserts after edge k+CLR_CYC. The first ARMED cycle has cnt=0.
  - Flag-to-capture latency: a flag rising before edge j is recorded SYNC_STAGES cycles later. The timestamp includes that offset; it is not compensated.
- Timeout: exactly window cycles in ARMED, then done_o=1 on the next cycle. Example: window=5 gives cnt 0..4 and DONE after the cnt=4 cycle.
- ack_i in DONE: done_o=0 and IDLE next cycle. A new start_i is accepted one cycle after that.
- Mid-run clrn assertion: immediate return to reset values and clr_o=1.

## Structure
- Shared package: state enum (IDLE, CLEAR, ARMED, DONE) and a helper function for lowest-set-bit index.
- Sub-module flag_sync: N_CH-wide, SYNC_STAGES-deep synchronizer with async clear to 0 on clrn.
- Everything else (FSM, counter, capture array, readout mux) in one file.

## Test plan
- Reset: clrn low -> clr_o=1, all other outputs 0. Release with start_i idle -> state stays IDLE.
- Full hit: mask=8'h0F, window=100, flags 2,0,3,1 rise at ARMED cnt 10,20,30,40.
  - ts = 12,22,32,42 (SYNC_STAGES=2); first_ch=2, first_ts=12.
  - done_o at the cnt=42 cycle +1; timeout_o=0.
- Timeout: mask=8'h03, window=5, only ch0 rises -> done_o after 5 ARMED cycles, timeout_o=1, hit_o=8'h01.
- Simultaneous hits: ch5 and ch3 rise on the same edge -> first_ch=3, both timestamps equal. Masked ch7 rising -> hit_o[7]=0.
- Abort and ignore: abort_i at cnt=7 -> IDLE, done_o never 1. start_i during ARMED -> ignored. ack_i in IDLE -> no effect.
- Edge cases:
  - window=0 with TS_W=4, mask=1, no flags -> 16 ARMED cycles then timeout_o=1.
  - mask=0 -> DONE after 1 ARMED cycle, timeout_o=0.
